// File: rtl/serial_stream_pkg.sv
// Shared types and limits for the serial bit-stream producers and consumers.
package serial_stream_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } serial_tx_state_t;

  localparam int SERIAL_MAX_WIDTH = 32;

endpackage

// File: rtl/serial_bit_counter.sv
// Loadable down-counter tracking the bits still to send; it never wraps below zero.
module serial_bit_counter
  import serial_stream_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          zero_o
);

  if (WIDTH < 2 || WIDTH > SERIAL_MAX_WIDTH) begin : g_width_check
    $error("serial_bit_counter: WIDTH must be between 2 and SERIAL_MAX_WIDTH");
  end

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = CW'(WIDTH - 1);
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/parallel_to_serial_msb_first.sv
// Accepts a parallel word over valid/ready and streams it MSB first, one bit per
// transfer, flagging the first and last bit so a serial checker can re-arm per word.
module parallel_to_serial_msb_first
  import serial_stream_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_word,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             new_bit,
  output logic             word_start,
  output logic             word_last
);

  localparam int CW = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > SERIAL_MAX_WIDTH) begin : g_width_check
    $error("parallel_to_serial_msb_first: WIDTH must be between 2 and SERIAL_MAX_WIDTH");
  end

  serial_tx_state_t state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    count;
  logic             cnt_zero;
  logic             in_shift;
  logic             xfer;
  logic             load;

  assign in_shift = (state_q == SHIFT);
  assign xfer     = in_shift && bit_ready;

  // Ready is also open on the last-bit transfer so consecutive words stream with no bubble.
  assign in_ready = !rst && (!in_shift || (cnt_zero && bit_ready));
  assign load     = in_valid && in_ready;

  assign bit_valid  = in_shift;
  assign new_bit    = in_shift && shreg_q[WIDTH-1];
  assign word_start = in_shift && (count == CW'(WIDTH - 1));
  assign word_last  = in_shift && cnt_zero;

  serial_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .dec_i   (xfer && !cnt_zero),
    .count_o (count),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shreg_q <= in_word;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (!cnt_zero) begin
              shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
            end else if (load) begin
              shreg_q <= in_word;
            end else begin
              shreg_q <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parallel_to_serial_msb_first.sv
// Scoreboard bench: accepted words queue their expected bit stream; a monitor checks every transfer.
module tb_parallel_to_serial_msb_first;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_word;
  logic         bit_valid;
  logic         bit_ready;
  logic         new_bit;
  logic         word_start;
  logic         word_last;

  int total = 0;
  int bad   = 0;
  int xfers = 0;

  typedef struct packed {
    logic b;
    logic s;
    logic l;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  parallel_to_serial_msb_first #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .new_bit    (new_bit),
    .word_start (word_start),
    .word_last  (word_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stimulus side of the scoreboard: an accepted word contributes W bits, MSB first.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) begin
      for (int i = W - 1; i >= 0; i--) begin
        exp_q.push_back('{b: 1'((in_word >> i) & 1), s: (i == W - 1), l: (i == 0)});
      end
    end
  end

  // Monitor: a reset drops any partial word; otherwise every transfer must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else if (bit_valid && bit_ready) begin
      xfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_bit_valid", bit_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        $display("xfer %0d: bit=%0d start=%0d last=%0d", xfers, new_bit, word_start, word_last);
        check("sb_bit", new_bit, e.b);
        check("sb_start", word_start, e.s);
        check("sb_last", word_last, e.l);
      end
    end
  end

  // Downstream divisibility-by-5 checker, re-armed by each word_start transfer.
  logic [2:0] rem_q;
  always @(posedge clk) begin
    if (rst) begin
      rem_q <= 3'd0;
    end else if (bit_valid && bit_ready) begin
      rem_q <= 3'(((word_start ? 0 : int'(rem_q)) * 2 + int'(new_bit)) % 5);
    end
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] w);
    bit got;
    got      = 1'b0;
    in_valid = 1'b1;
    in_word  = w;
    for (int c = 0; c < 4 * W && !got; c++) begin
      @(negedge clk);
      got = in_ready;
      cyc();
    end
    in_valid = 1'b0;
    check("send_accept", got, 1'b1);
  endtask

  task automatic drain;
    bit seen;
    seen = 1'b0;
    for (int c = 0; c < 8 * W && !seen; c++) begin
      @(negedge clk);
      seen = bit_valid && bit_ready && word_last;
      cyc();
    end
    check("drain_last", seen, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int accepted;
    int sent;

    // Reset with a word offered: reset wins, in_ready held low.
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_word   = 8'h3C;
    bit_ready = 1'b1;
    cyc();
    cyc();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_bit_valid", bit_valid, 1'b0);
    cyc();
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_in_ready", in_ready, 1'b1);
      check("idle_bit_valid", bit_valid, 1'b0);
      check("idle_new_bit", new_bit, 1'b0);
      check("idle_flags", {word_start, word_last}, 2'b00);
      cyc();
    end

    // Single word A5: bits in N+1..N+8, idle again at N+9.
    send(8'hA5);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check("a5_valid", bit_valid, 1'b1);
      check("a5_start", word_start, k == 1);
      check("a5_last", word_last, k == W);
      cyc();
    end
    @(negedge clk);
    check("a5_idle_valid", bit_valid, 1'b0);
    check("a5_idle_ready", in_ready, 1'b1);
    cyc();

    // Back-to-back 0F then F0 with in_valid held high.
    in_valid = 1'b1;
    in_word  = 8'h0F;
    accepted = 0;
    for (int c = 0; c < 6 * W && accepted < 2; c++) begin
      @(negedge clk);
      if (accepted > 0) begin
        check("b2b_valid", bit_valid, 1'b1);
        check("b2b_ready_pulse", in_ready, word_last);
      end
      if (in_valid && in_ready) accepted++;
      cyc();
      if (accepted == 1) in_word = 8'hF0;
      if (accepted == 2) in_valid = 1'b0;
    end
    check("b2b_accepted", 32'(accepted), 32'd2);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("b2b_valid2", bit_valid, 1'b1);
      check("b2b_ready_pulse2", in_ready, word_last);
      cyc();
    end
    @(negedge clk);
    check("b2b_idle", bit_valid, 1'b0);
    cyc();

    // Stall after bit 2 of 81 for three cycles.
    base = xfers;
    send(8'h81);
    cyc();
    cyc();
    bit_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("stall_valid", bit_valid, 1'b1);
      check("stall_bit", new_bit, 1'b0);
      check("stall_flags", {word_start, word_last}, 2'b00);
      check("stall_in_ready", in_ready, 1'b0);
      cyc();
    end
    bit_ready = 1'b1;
    drain();
    check("stall_xfer_count", 32'(xfers - base), 32'(W));

    // Reset after three bits of FF, then a clean 05.
    send(8'hFF);
    cyc();
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_valid", bit_valid, 1'b0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_last", word_last, 1'b0);
    cyc();
    send(8'h05);
    @(negedge clk);
    check("post_rst_start", word_start, 1'b1);
    check("post_rst_bit", new_bit, 1'b0);
    cyc();
    drain();

    // End-to-end with the divisibility-by-5 checker.
    send(8'd25);
    drain();
    @(negedge clk);
    check("div5_25", rem_q == 3'd0, (25 % 5) == 0);
    cyc();
    send(8'd26);
    drain();
    @(negedge clk);
    check("div5_26", rem_q == 3'd0, (26 % 5) == 0);
    cyc();

    // Random words with random backpressure and gaps.
    sent = 0;
    for (int c = 0; c < 4000 && sent < 40; c++) begin
      bit accepted_now;
      bit_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid && ($urandom_range(0, 2) != 0)) begin
        in_valid = 1'b1;
        in_word  = W'($urandom);
      end
      @(negedge clk);
      accepted_now = in_valid && in_ready;
      cyc();
      if (accepted_now) begin
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    bit_ready = 1'b1;
    check("rand_sent", 32'(sent), 32'd40);
    for (int c = 0; c < 4 * W && exp_q.size() != 0; c++) begin
      cyc();
    end
    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_idle", bit_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
